// File: rtl/vect_fwd_ctrl_if.sv
// rtl/vect_fwd_ctrl_if.sv - decode-side and execute-side bundle of the vector hazard/forwarding controller
interface vect_fwd_ctrl_if #(
   parameter int RA_W  = 4,
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [RA_W-1:0]  id_ra1;
   logic [RA_W-1:0]  id_ra2;
   logic [RA_W-1:0]  id_ra3;
   logic             id_use1;
   logic             id_use2;
   logic             id_use3;
   logic [RA_W-1:0]  id_wa;
   logic             id_reg_write;
   logic             id_mem_to_reg;
   logic             id_imm_src;
   logic             id_zero_b;
   logic             mem_busy;
   logic             flush;

   logic             stall_id;
   logic             ex_valid;
   logic             ex_reg_write;
   logic             ex_mem_to_reg;
   logic [RA_W-1:0]  ex_wa;
   logic             Fa;
   logic             Fb;
   logic             immSrc;
   logic             Fc;
   logic             mem_valid;
   logic             mem_reg_write;
   logic [RA_W-1:0]  mem_wa;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_ra1, id_ra2, id_ra3, id_use1, id_use2, id_use3,
             id_wa, id_reg_write, id_mem_to_reg, id_imm_src, id_zero_b,
             mem_busy, flush,
      input  stall_id, ex_valid, ex_reg_write, ex_mem_to_reg, ex_wa,
             Fa, Fb, immSrc, Fc, mem_valid, mem_reg_write, mem_wa, stall_count
   );

   modport slave (
      input  id_valid, id_ra1, id_ra2, id_ra3, id_use1, id_use2, id_use3,
             id_wa, id_reg_write, id_mem_to_reg, id_imm_src, id_zero_b,
             mem_busy, flush,
      output stall_id, ex_valid, ex_reg_write, ex_mem_to_reg, ex_wa,
             Fa, Fb, immSrc, Fc, mem_valid, mem_reg_write, mem_wa, stall_count
   );
endinterface

// File: rtl/vect_fwd_ctrl.sv
// rtl/vect_fwd_ctrl.sv - load-use hazard detection, EX->EX forwarding selects and EX/MEM control pipeline
module vect_fwd_ctrl #(
   parameter int RA_W  = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   vect_fwd_ctrl_if.slave   bus
);

   logic             ex_valid_q, ex_valid_d;
   logic             ex_reg_write_q, ex_reg_write_d;
   logic             ex_mem_to_reg_q, ex_mem_to_reg_d;
   logic [RA_W-1:0]  ex_wa_q, ex_wa_d;
   logic             fa_q, fa_d;
   logic             fb_q, fb_d;
   logic             imm_src_q, imm_src_d;
   logic             fc_q, fc_d;
   logic             mem_valid_q, mem_valid_d;
   logic             mem_reg_write_q, mem_reg_write_d;
   logic [RA_W-1:0]  mem_wa_q, mem_wa_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             flush_pend_q, flush_pend_d;

   logic adv;
   logic load_in_ex;
   logic alu_in_ex;
   logic match1, match2, match3;
   logic hz;
   logic squash;
   logic hz_stall;
   logic bubble;
   logic fwd1, fwd2, fwd3;

   always_comb begin
      adv        = !bus.mem_busy;
      load_in_ex = ex_valid_q & ex_reg_write_q & ex_mem_to_reg_q;
      alu_in_ex  = ex_valid_q & ex_reg_write_q & !ex_mem_to_reg_q;
      match1     = bus.id_use1 & (bus.id_ra1 == ex_wa_q);
      // An immediate operand B never reads rd2, so it cannot create a load-use hazard.
      match2     = bus.id_use2 & !bus.id_imm_src & (bus.id_ra2 == ex_wa_q);
      match3     = bus.id_use3 & (bus.id_ra3 == ex_wa_q);
      hz         = load_in_ex & bus.id_valid & (match1 | match2 | match3);
      squash     = bus.flush | flush_pend_q;
      hz_stall   = hz & !squash;
      bubble     = !bus.id_valid | hz | squash;
      fwd1       = alu_in_ex & match1;
      fwd2       = alu_in_ex & bus.id_use2 & (bus.id_ra2 == ex_wa_q);
      fwd3       = alu_in_ex & match3;
   end

   always_comb begin
      ex_valid_d      = ex_valid_q;
      ex_reg_write_d  = ex_reg_write_q;
      ex_mem_to_reg_d = ex_mem_to_reg_q;
      ex_wa_d         = ex_wa_q;
      fa_d            = fa_q;
      fb_d            = fb_q;
      imm_src_d       = imm_src_q;
      fc_d            = fc_q;
      mem_valid_d     = mem_valid_q;
      mem_reg_write_d = mem_reg_write_q;
      mem_wa_d        = mem_wa_q;
      stall_count_d   = stall_count_q;
      // A flush seen during a freeze is remembered and consumed by the next advance.
      flush_pend_d    = flush_pend_q | bus.flush;

      if (adv) begin
         mem_valid_d     = ex_valid_q;
         mem_reg_write_d = ex_reg_write_q;
         mem_wa_d        = ex_wa_q;
         flush_pend_d    = 1'b0;

         if (bubble) begin
            ex_valid_d      = 1'b0;
            ex_reg_write_d  = 1'b0;
            ex_mem_to_reg_d = 1'b0;
            ex_wa_d         = '0;
            fa_d            = 1'b0;
            fb_d            = 1'b0;
            imm_src_d       = 1'b0;
            fc_d            = 1'b0;
         end else begin
            ex_valid_d      = 1'b1;
            ex_reg_write_d  = bus.id_reg_write;
            ex_mem_to_reg_d = bus.id_mem_to_reg;
            ex_wa_d         = bus.id_wa;
            fa_d            = fwd1;
            fc_d            = fwd3;
            if (bus.id_imm_src) begin
               fb_d      = bus.id_zero_b;
               imm_src_d = 1'b1;
            end else begin
               fb_d      = fwd2;
               imm_src_d = 1'b0;
            end
         end

         if (hz_stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q      <= 1'b0;
         ex_reg_write_q  <= 1'b0;
         ex_mem_to_reg_q <= 1'b0;
         ex_wa_q         <= '0;
         fa_q            <= 1'b0;
         fb_q            <= 1'b0;
         imm_src_q       <= 1'b0;
         fc_q            <= 1'b0;
         mem_valid_q     <= 1'b0;
         mem_reg_write_q <= 1'b0;
         mem_wa_q        <= '0;
         stall_count_q   <= '0;
         flush_pend_q    <= 1'b0;
      end else begin
         ex_valid_q      <= ex_valid_d;
         ex_reg_write_q  <= ex_reg_write_d;
         ex_mem_to_reg_q <= ex_mem_to_reg_d;
         ex_wa_q         <= ex_wa_d;
         fa_q            <= fa_d;
         fb_q            <= fb_d;
         imm_src_q       <= imm_src_d;
         fc_q            <= fc_d;
         mem_valid_q     <= mem_valid_d;
         mem_reg_write_q <= mem_reg_write_d;
         mem_wa_q        <= mem_wa_d;
         stall_count_q   <= stall_count_d;
         flush_pend_q    <= flush_pend_d;
      end
   end

   assign bus.stall_id      = bus.mem_busy | hz_stall;
   assign bus.ex_valid      = ex_valid_q;
   assign bus.ex_reg_write  = ex_reg_write_q;
   assign bus.ex_mem_to_reg = ex_mem_to_reg_q;
   assign bus.ex_wa         = ex_wa_q;
   assign bus.Fa            = fa_q;
   assign bus.Fb            = fb_q;
   assign bus.immSrc        = imm_src_q;
   assign bus.Fc            = fc_q;
   assign bus.mem_valid     = mem_valid_q;
   assign bus.mem_reg_write = mem_reg_write_q;
   assign bus.mem_wa        = mem_wa_q;
   assign bus.stall_count   = stall_count_q;

endmodule

// File: doc/vect_fwd_ctrl.md
Name: vect_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 2-lane vector pipeline.
- Drives the select inputs of the vector execute stage: Fa, {Fb,immSrc}, Fc.
- Tracks the destination register of the instructions in EX and MEM, detects load-use hazards, and stalls decode.
- Holds the EX/MEM control pipeline registers and issues bubbles on stall or flush.

Parameters:
- RA_W, 4, vector register address width (16 vector registers).
- CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode holds a valid instruction.
- id_ra1  in  RA_W  source A register (rd1 operand).
- id_ra2  in  RA_W  source B register (rd2 operand).
- id_ra3  in  RA_W  source C register (rd3, store-data operand).
- id_use1, id_use2, id_use3  in  1 each  corresponding source is actually read.
- id_wa  in  RA_W  destination register.
- id_reg_write  in  1  instruction writes id_wa.
- id_mem_to_reg  in  1  instruction is a vector load.
- id_imm_src  in  1  operand B comes from the immediate path.
- id_zero_b  in  1  with id_imm_src, operand B is forced to 0.
- mem_busy  in  1  downstream freeze: no stage advances.
- flush  in  1  squash the instruction in decode.
- stall_id  out  1  hold the fetch/decode registers this cycle.
- ex_valid, ex_reg_write, ex_mem_to_reg  out  1 each  EX-stage control.
- ex_wa  out  RA_W  EX-stage destination.
- Fa, Fb, immSrc, Fc  out  1 each  registered selects for the execute stage.
- mem_valid, mem_reg_write  out  1 each  MEM-stage control.
- mem_wa  out  RA_W  MEM-stage destination; its result is the forward source.
- stall_count  out  CNT_W  number of load-use stall cycles.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs, including stall_count, go to 0. The internal flush_pend flag clears.
- adv = !mem_busy.
- On posedge with adv:
  - MEM <= EX.
  - EX <= new entry, or a bubble (all control 0, selects 0).
- While mem_busy=1, EX, MEM and the selects hold their values.
- hz (combinational) is 1 when all of the following hold:
  - ex_valid & ex_reg_write & ex_mem_to_reg & id_valid
  - at least one source matches: (id_use1 & id_ra1==ex_wa) | (id_use2 & !id_imm_src & id_ra2==ex_wa) | (id_use3 & id_ra3==ex_wa)
- stall_id = mem_busy | (hz & !flush & !flush_pend).
- Bubble condition: !id_valid | hz | flush | flush_pend.
- Forward match fwdX is ex_valid & ex_reg_write & !ex_mem_to_reg & id_useX & (id_raX==ex_wa). The EX producer is in MEM when the consumer reaches EX.
- Registered selects on a non-bubble advance:
  - Fa = fwd1.
  - Fc = fwd3.
  - {Fb,immSrc}: if id_imm_src, 01, or 11 when id_zero_b (B=0). Otherwise 10 when fwd2, else 00.
- Distance-2 dependencies (producer in WB) are not forwarded. The register file is write-first, so rd1/rd2/rd3 already carry the value.
- Load-use sequence:
  - Cycle 1: one bubble is inserted.
  - Cycle 2: the load is in MEM and the consumer re-evaluates. ex_mem_to_reg is now 0 for the bubble, so there is no hazard and no forward.
  - Cycle 3: the consumer enters EX while the load is in WB (regfile write-first).
- Flush:
  - flush with adv: EX gets a bubble and hz is ignored.
  - flush with mem_busy: flush_pend is set. It is applied as a bubble on the next adv, then cleared.
- Simultaneous hz and mem_busy: only mem_busy is in effect. stall_count does not increment.
- stall_count increments on each posedge where adv & hz & !flush & !flush_pend. It saturates at all-ones and does not wrap.
- Latency: selects are visible the cycle after the decode instruction's advance edge. This matches the execute stage, which consumes them with rd1/rd2/rd3 in that cycle.

Test Plan:
- Back-to-back dependency, forward on A: ADD v3=v1+v2, then ADD v4=v3+v5 (use1,use2). -> Second instruction in EX with Fa=1, Fb=0, immSrc=0. stall_id never asserted.
- Immediate and zero B:
  - id_imm_src=1, id_zero_b=0 -> {Fb,immSrc}=01.
  - id_zero_b=1 -> 11.
  - id_ra2 matching ex_wa with imm_src=1 -> no forward, no hazard.
- Load-use: LOAD v6, then ADD v7=v6+v6 -> stall_id=1 for exactly 1 cycle. One EX bubble (ex_valid=0). Consumer enters EX with Fa=0, Fb=0. stall_count 0->1.
- Store-data forward: ADD v2, then STORE with use3 on ra3=v2 -> Fc=1. Fc=0 when the producer is 2 instructions ahead.
- mem_busy for 3 cycles during a dependent pair -> EX/MEM/selects frozen for 3 cycles and stall_id=1. flush asserted during busy -> bubble on the first advance, flush_pend cleared after it.
- Reset mid-stream, with ex_valid=1, mem_valid=1, stall_count=5: pull rst_n low asynchronously between edges -> all outputs 0 immediately, before the next posedge.
